fft_input_reorder: RTL

Streaming bit-reversal buffer placed directly upstream of the first `butterfly2` column in the 16-point FFT. It accepts complex Q8 fixed-point samples in natural order, one per handshake. It emits each 16-sample frame in bit-reversed order so the radix-2 butterfly stages receive their operand pairs in the order they consume them. Two ping-pong banks let one frame be written while the previous one is read, sustaining one sample per clock.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_sample_bank.sv | 32 +++
 rtl/fft_input_reorder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, the bit-reversal helper used both by
// the input reorder buffer and by later-stage twiddle addressing, and the
// complex sample layout.
package fft_pkg;

    localparam int unsigned FFT_POINTS = 16;
    localparam int unsigned FFT_LOG2   = 4;

    // Default component width of the Q8 datapath. Packages cannot take
    // parameters, so width-generic modules declare a local struct with the
    // same {re, im} field order at their own width N.
    localparam int unsigned FFT_N = 16;

    typedef struct packed {
        logic signed [FFT_N-1:0] re;
        logic signed [FFT_N-1:0] im;
    } fft_cplx_t;

    // Mirror the four address bits: 0,1,2,3 -> 0,8,4,12.
    function automatic logic [FFT_LOG2-1:0] bitrev4(input logic [FFT_LOG2-1:0] a);
        return {a[0], a[1], a[2], a[3]};
    endfunction

endpackage

// File: rtl/fft_sample_bank.sv
// One 16-entry bank of packed complex samples.
//   i_clk   : clock, writes on rising edge
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data {re, im}
//   i_raddr : read address (asynchronous read)
//   o_rdata : read data
// Contents are intentionally not reset; the owner tracks validity with flags.
module fft_sample_bank
    import fft_pkg::*;
#(
    parameter int unsigned W = 2 * FFT_N
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [FFT_LOG2-1:0] i_waddr,
    input  logic [W-1:0]        i_wdata,
    input  logic [FFT_LOG2-1:0] i_raddr,
    output logic [W-1:0]        o_rdata
);

    logic [W-1:0] mem_q [FFT_POINTS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fft_input_reorder.sv
// Streaming bit-reversal buffer ahead of the first butterfly column.
// Accepts samples in natural order and emits each 16-sample frame in
// bit-reversed order, ping-ponging between two banks so one frame fills while
// the previous one drains.
//   i_clk, i_rst        : clock, asynchronous active-low reset
//   i_valid/o_ready     : input handshake; i_re/i_im input sample
//   o_valid/i_ready     : output handshake; o_re/o_im output sample
//   o_index             : position k of the output within the frame
//   o_last              : marks k = 15
module fft_input_reorder
    import fft_pkg::*;
#(
    parameter int unsigned N      = 16,
    parameter int unsigned POINTS = FFT_POINTS
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [N-1:0]        i_re,
    input  logic [N-1:0]        i_im,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [N-1:0]        o_re,
    output logic [N-1:0]        o_im,
    output logic [FFT_LOG2-1:0] o_index,
    output logic                o_last
);

    localparam int unsigned LOG2 = FFT_LOG2;
    localparam logic [LOG2-1:0] CntMax = LOG2'(POINTS - 1);

    typedef struct packed {
        logic [N-1:0] re;
        logic [N-1:0] im;
    } cplx_t;

    localparam int unsigned W = $bits(cplx_t);

    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, rd_bank_q;
    logic [LOG2-1:0] wr_cnt_q, rd_cnt_q;

    logic wr_fire, rd_fire;
    logic wr_done, rd_done;

    cplx_t           wr_sample;
    cplx_t           rd_sample;
    logic [W-1:0]    rd_data [2];
    logic [LOG2-1:0] rd_addr;

    // Handshakes
    assign o_ready = ~full_q[wr_bank_q];
    assign o_valid = full_q[rd_bank_q];
    assign wr_fire = i_valid & o_ready;
    assign rd_fire = o_valid & i_ready;
    assign wr_done = wr_fire & (wr_cnt_q == CntMax);
    assign rd_done = rd_fire & (rd_cnt_q == CntMax);

    assign wr_sample = '{re: i_re, im: i_im};
    assign rd_addr   = bitrev4(rd_cnt_q);

    // Bank storage
    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_sample_bank #(
            .W (W)
        ) u_bank (
            .i_clk   (i_clk),
            .i_we    (wr_fire && (wr_bank_q == 1'(b))),
            .i_waddr (wr_cnt_q),
            .i_wdata (wr_sample),
            .i_raddr (rd_addr),
            .o_rdata (rd_data[b])
        );
    end

    // Flag next state. A bank cannot be both the write target (needs empty)
    // and the read source (needs full) in one cycle, so the two updates
    // never collide on the same bit.
    always_comb begin
        full_d = full_q;
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // State
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            if (wr_fire) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (wr_done) begin
                    wr_bank_q <= ~wr_bank_q;
                end
            end
            if (rd_fire) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
                if (rd_done) begin
                    rd_bank_q <= ~rd_bank_q;
                end
            end
        end
    end

    // Outputs: combinational read, forced to zero when nothing is presented.
    // Holding under backpressure falls out of rd_cnt_q/rd_bank_q not moving.
    always_comb begin
        rd_sample = rd_bank_q ? cplx_t'(rd_data[1]) : cplx_t'(rd_data[0]);
        o_re      = '0;
        o_im      = '0;
        o_index   = '0;
        o_last    = 1'b0;
        if (o_valid) begin
            o_re    = rd_sample.re;
            o_im    = rd_sample.im;
            o_index = rd_cnt_q;
            o_last  = (rd_cnt_q == CntMax);
        end
    end

endmodule
